uart_rx_fifo: RTL and testbench

//   Receive-side byte buffer sitting directly downstream of the UART receiver.

---
 rtl/uart_rx_fifo.sv | 107 ++++++++++
 tb/tb_uart_rx_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for the UART receiver.
// First-word-fall-through output with a valid/ready handshake.
// Accepts a push while full only when a pop happens in the same cycle.
// A byte that arrives while full with no pop is dropped and sets a sticky overrun flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // The pointers carry one extra wrap bit. This keeps the full and empty states distinct.
    localparam logic [PW-1:0] PtrOne    = PW'(1);
    localparam logic [PW-1:0] DepthVal  = PW'(DEPTH);
    localparam logic [PW-1:0] AfullVal  = PW'(AFULL_THRESH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overrun_q, overrun_d;

    logic [PW-1:0] level_w;
    logic          empty_w;
    logic          full_w;
    logic          pop;
    logic          push;
    logic          drop;

    // Status flags come only from the registered pointers, so they always agree with each other.
    always_comb begin
        level_w     = wr_ptr_q - rd_ptr_q;
        empty_w     = (level_w == '0);
        full_w      = (level_w == DepthVal);
        level       = level_w;
        empty       = empty_w;
        full        = full_w;
        almost_full = (level_w >= AfullVal);
        overrun     = overrun_q;
    end

    // FWFT output: the head entry is driven straight from the storage array.
    always_comb begin
        out_valid = !empty_w;
        out_data  = empty_w ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Handshake decode. When full, a push is accepted only if a pop frees a slot in the same cycle.
    always_comb begin
        pop  = out_valid & out_ready;
        push = in_valid & (!full_w | pop);
        drop = in_valid & full_w & !pop;
    end

    // Pointer and overrun next-state. If a drop and a clear happen together, the drop wins.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage write. The array is not reset, and a push during reset is ignored.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DEPTH 16, AFULL_THRESH 12).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overrun;
    logic       overrun_clr;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(
        .DEPTH        (16),
        .AFULL_THRESH (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Advance one clock. Inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            checks++;
            if (level !== 5'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
            checks++;
            if (almost_full !== (i + 1 >= 12)) begin
                errors++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= 12));
            end
            checks++;
            if (full !== (i + 1 == 16)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i + 1 == 16)); end
            checks++;
            if (out_data !== 8'h00) begin errors++; $display("FAIL fill_head[%0d] got=%h exp=00", i, out_data); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_drop();
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL drop_level got=%0d exp=16", level); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL drop_overrun got=%b exp=1", overrun); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL drop_head got=%h exp=00", out_data); end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL pp_level got=%0d exp=16", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pp_overrun got=%b exp=0", overrun); end
        for (int i = 1; i <= 16; i++) begin
            exp = (i == 16) ? 8'h55 : 8'(i);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                errors++; $display("FAIL drain[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, exp);
            end
            step();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL drain_out_data got=%h exp=00", out_data); end
    endtask

    task automatic test_stream();
        int sent = 0;
        int rcvd = 0;
        int lvl  = 0;
        int cyc  = 0;
        logic pop_m;
        logic push_m;
        do_reset();
        while (rcvd < 40 && cyc < 400) begin
            in_valid  = (sent < 40);
            in_data   = 8'h80 + 8'(sent);
            out_ready = (lvl == 16) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            pop_m  = (lvl > 0) && out_ready;
            push_m = in_valid;
            checks++;
            if (out_valid !== (lvl > 0)) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=%b", cyc, out_valid, lvl > 0); end
            if (pop_m) begin
                checks++;
                if (out_data !== 8'h80 + 8'(rcvd)) begin
                    errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", rcvd, out_data, 8'h80 + 8'(rcvd));
                end
                rcvd++;
            end
            if (push_m) sent++;
            lvl = lvl + int'(push_m) - int'(pop_m);
            step();
            cyc++;
            checks++;
            if (level !== 5'(lvl)) begin errors++; $display("FAIL stream_level[%0d] got=%0d exp=%0d", cyc, level, lvl); end
        end
        idle_inputs();
        checks++; if (rcvd !== 40) begin errors++; $display("FAIL stream_count got=%0d exp=40", rcvd); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL stream_overrun got=%b exp=0", overrun); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got=%b exp=1", empty); end
    endtask

    task automatic test_drop_vs_clr();
        do_reset();
        fill(8'h10);
        in_valid    = 1'b1;
        in_data     = 8'hEE;
        overrun_clr = 1'b1;
        step();
        idle_inputs();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL drop_clr_overrun got=%b exp=1", overrun); end
        checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL drop_clr_head got=%h exp=10", out_data); end
    endtask

    task automatic test_single_push();
        do_reset();
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        out_ready = 1'b1;
        step();
        idle_inputs();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL single_data got=%h exp=3c", out_data); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill(8'h20);
        in_valid = 1'b1;
        in_data  = 8'hBB;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        out_ready = 1'b0;
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL mid_pre_level got=%0d exp=5", level); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL mid_pre_overrun got=%b exp=1", overrun); end
        checks++; if (out_data !== 8'h2B) begin errors++; $display("FAIL mid_pre_head got=%h exp=2b", out_data); end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got=%b exp=0", overrun); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data got=%h exp=00", out_data); end
        step();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_after_level got=%0d exp=0", level); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_drop();
        test_push_pop_full();
        test_stream();
        test_drop_vs_clr();
        test_single_push();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
